// File: rtl/regfile.sv
// RV32I integer register file: x1-x31 held in register_32bit instances, x0 reads as zero.
// Three combinational read ports (rs1, rs2, debug) and one write port that captures on the rising edge.

module register_32bit (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);

  logic [31:0] data_q;
  logic [31:0] data_d;

  always_comb begin
    data_d = data_q;
    if (i_en) data_d = i_d;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) data_q <= 32'h0;
    else         data_q <= data_d;
  end

  assign o_q = data_q;

endmodule

module regfile (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rd_wren,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd_data,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  input  logic [4:0]  i_dbg_addr,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  output logic [31:0] o_dbg_data
);

  // Bit 0 of the write decode would target x0, so it is never built.
  logic [31:1] wr_en;
  logic [31:0] regs [32];

  always_comb begin
    wr_en = '0;
    for (int i = 1; i < 32; i++) begin
      wr_en[i] = i_rd_wren && (i_rd_addr == 5'(i));
    end
  end

  assign regs[0] = 32'h0;

  for (genvar g = 1; g < 32; g++) begin : g_reg
    register_32bit u_reg (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (wr_en[g]),
      .i_d     (i_rd_data),
      .o_q     (regs[g])
    );
  end

  // No write bypass: reads show the stored value until the capturing edge.
  assign o_rs1_data = regs[i_rs1_addr];
  assign o_rs2_data = regs[i_rs2_addr];
  assign o_dbg_data = regs[i_dbg_addr];

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: array reference model checked every cycle plus directed literal checks.
`timescale 1ns/1ps

module tb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wren = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] wd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [4:0]  dbg = '0;
  logic [31:0] rs1_data, rs2_data, dbg_data;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  logic [31:0] mdl [32];

  regfile dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_rd_wren  (wren),
    .i_rd_addr  (rd),
    .i_rd_data  (wd),
    .i_rs1_addr (rs1),
    .i_rs2_addr (rs2),
    .i_dbg_addr (dbg),
    .o_rs1_data (rs1_data),
    .o_rs2_data (rs2_data),
    .o_dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : mdl[a];
  endfunction

  // Reference model: reset clears everything at once, a write lands on the edge.
  always @(posedge rst) begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    end else if (wren === 1'b1 && rd != 5'd0) begin
      mdl[rd] = wd;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_rs1", rs1_data, model_rd(rs1));
      check("cmp_rs2", rs2_data, model_rd(rs2));
      check("cmp_dbg", dbg_data, model_rd(dbg));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    rst = 1'b1;
    step();
    cmp_en = 1'b1;

    // Reset sweep: every port reads zero.
    for (int a = 0; a < 32; a++) begin
      rs1 = 5'(a); rs2 = 5'(31 - a); dbg = 5'(a);
      #1;
      check("rst_sweep_rs1", rs1_data, 32'h0);
      check("rst_sweep_rs2", rs2_data, 32'h0);
      check("rst_sweep_dbg", dbg_data, 32'h0);
      step();
    end
    rst = 1'b0;
    step();

    // x0 write dropped.
    wren = 1'b1; rd = 5'd0; wd = 32'hFFFF_FFFF;
    step();
    wren = 1'b0; rs1 = 5'd0; rs2 = 5'd0; dbg = 5'd0;
    #1;
    check("x0_rs1", rs1_data, 32'h0);
    check("x0_rs2", rs2_data, 32'h0);
    check("x0_dbg", dbg_data, 32'h0);
    step();

    // Basic write/read.
    wren = 1'b1; rd = 5'd5; wd = 32'hDEAD_BEEF;
    step();
    wren = 1'b0; rs1 = 5'd5; rs2 = 5'd5; dbg = 5'd5;
    #1;
    check("x5_rs1", rs1_data, 32'hDEAD_BEEF);
    check("x5_rs2", rs2_data, 32'hDEAD_BEEF);
    check("x5_dbg", dbg_data, 32'hDEAD_BEEF);
    for (int a = 1; a < 32; a++) begin
      if (a != 5) begin
        dbg = 5'(a);
        #1;
        check("x5_others", dbg_data, 32'h0);
      end
    end
    step();

    // Boundaries x1 and x31 on consecutive edges.
    wren = 1'b1; rd = 5'd1; wd = 32'h1;
    step();
    rd = 5'd31; wd = 32'h8000_0000;
    step();
    wren = 1'b0; rs1 = 5'd1; rs2 = 5'd31;
    #1;
    check("x1", rs1_data, 32'h1);
    check("x31", rs2_data, 32'h8000_0000);
    for (int a = 2; a < 31; a++) begin
      dbg = 5'(a);
      #1;
      check("x2_30_iso", dbg_data, (a == 5) ? 32'hDEAD_BEEF : 32'h0);
    end
    step();

    // Read during write: old value before the edge, new value after.
    wren = 1'b1; rd = 5'd7; wd = 32'h0000_00AA;
    step();
    rs1 = 5'd7; wd = 32'h0000_0055;
    #1;
    check("rdw_before", rs1_data, 32'h0000_00AA);
    step();
    wren = 1'b0;
    #1;
    check("rdw_after", rs1_data, 32'h0000_0055);
    wd = 32'h0000_1234;
    step();
    check("wren0_hold", rs1_data, 32'h0000_0055);
    rd = 'x;
    step();
    check("x_addr_hold", rs1_data, 32'h0000_0055);
    rd = 5'd0;

    // Fill with index values, then pulse reset between edges.
    wren = 1'b1;
    for (int a = 1; a < 32; a++) begin
      rd = 5'(a); wd = 32'(a);
      step();
    end
    wren = 1'b0; rs1 = 5'd7; rs2 = 5'd31; dbg = 5'd1;
    #1;
    check("fill_x7", rs1_data, 32'd7);
    check("fill_x31", rs2_data, 32'd31);
    rst = 1'b1;
    #1;
    check("async_rs1", rs1_data, 32'h0);
    check("async_rs2", rs2_data, 32'h0);
    check("async_dbg", dbg_data, 32'h0);
    rst = 1'b0;
    step();

    // A write coinciding with reset is lost; the first edge after release writes.
    rst = 1'b1; wren = 1'b1; rd = 5'd9; wd = 32'h0000_CAFE;
    step();
    rst = 1'b0; wren = 1'b0; dbg = 5'd9;
    #1;
    check("wr_during_rst", dbg_data, 32'h0);
    wren = 1'b1;
    step();
    wren = 1'b0;
    #1;
    check("wr_after_rel", dbg_data, 32'h0000_CAFE);
    step();

    // Random regression against the array model.
    for (int n = 0; n < 10000; n++) begin
      wren = 1'($urandom_range(0, 1));
      rd   = 5'($urandom_range(0, 31));
      wd   = $urandom;
      rs1  = 5'($urandom_range(0, 31));
      rs2  = 5'($urandom_range(0, 31));
      dbg  = 5'($urandom_range(0, 31));
      step();
    end
    wren = 1'b0;
    step();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
